// File: rtl/icache_pkg.sv
// Shared encodings and line geometry for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    ICACHE_IDLE   = 2'd0,
    ICACHE_REFILL = 2'd1,
    ICACHE_RESP   = 2'd2
  } icache_state_e;

  localparam int LINE_OFF_W     = 4;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_SEL_W     = 2;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read of one line, synchronous per-word
// write, and an install strobe that writes the tag and sets the valid bit.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 22
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [INDEX_W-1:0]                   rd_idx,
  output logic                                 rd_valid,
  output logic [TAG_W-1:0]                     rd_tag,
  output logic [WORDS_PER_LINE-1:0][31:0]      rd_data,
  input  logic [INDEX_W-1:0]                   wr_idx,
  input  logic                                 wr_en,
  input  logic [WORD_SEL_W-1:0]                wr_word,
  input  logic [31:0]                          wr_data,
  input  logic                                 install,
  input  logic [TAG_W-1:0]                     install_tag
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]                    valid_q, valid_d;
  logic [TAG_W-1:0]                    tag_q  [LINES];
  logic [WORDS_PER_LINE-1:0][31:0]     data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (install) valid_d[wr_idx] = 1'b1;
  end

  // Only the valid bits need reset; tags and data are qualified by them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en)   data_q[wr_idx][wr_word] <= wr_data;
    if (install) tag_q[wr_idx]           <= install_tag;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache top: FSM, refill counter and address logic.
// Define ICACHE_EN to build the cached version; otherwise every fetch is a single-word read.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  input  logic              flush,
  output logic [31:0]       ins_out,
  output logic              ins_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data
);

  localparam int TAG_W = ADDR_W - LINE_OFF_W - INDEX_W;

  icache_state_e           state_q, state_d;
  logic [ADDR_W-1:0]       req_pc_q, req_pc_d;
  logic [WORD_SEL_W-1:0]   cnt_q, cnt_d;
  logic [31:0]             ins_out_q, ins_out_d;
  logic                    discard_q, discard_d;
  logic                    accept;
  logic                    unused_lsbs;

  assign unused_lsbs = ^req_pc_q[1:0];

  // Suppressed during a discarded response, a same-cycle flush, or a stall.
  assign ins_valid = (state_q == ICACHE_RESP) && rdy && !discard_q && !flush;
  assign accept    = pc_valid && !flush && !ins_valid;
  assign mem_req   = (state_q == ICACHE_REFILL);
  assign ins_out   = ins_out_q;

`ifdef ICACHE_EN
  logic                               rd_valid, hit, wr_en, install;
  logic [TAG_W-1:0]                   rd_tag;
  logic [WORDS_PER_LINE-1:0][31:0]    rd_data;
  logic [INDEX_W-1:0]                 rd_idx, req_idx;
  logic [WORD_SEL_W-1:0]              req_word;

  assign req_idx  = req_pc_q[LINE_OFF_W +: INDEX_W];
  assign req_word = req_pc_q[LINE_OFF_W-1:2];
  assign rd_idx   = (state_q == ICACHE_IDLE) ? pc_in[LINE_OFF_W +: INDEX_W] : req_idx;
  assign hit      = rd_valid && (rd_tag == pc_in[ADDR_W-1 -: TAG_W]);
  assign mem_addr = {req_pc_q[ADDR_W-1:LINE_OFF_W], cnt_q, 2'b00};

  icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .rd_idx      (rd_idx),
    .rd_valid    (rd_valid),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_idx      (req_idx),
    .wr_en       (wr_en),
    .wr_word     (cnt_q),
    .wr_data     (mem_data),
    .install     (install),
    .install_tag (req_pc_q[ADDR_W-1 -: TAG_W])
  );
`else
  assign mem_addr = {req_pc_q[ADDR_W-1:2], 2'b00};
`endif

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    cnt_d     = cnt_q;
    ins_out_d = ins_out_q;
    discard_d = discard_q;
`ifdef ICACHE_EN
    wr_en     = 1'b0;
    install   = 1'b0;
`endif
    if (rdy) begin
      unique case (state_q)
        ICACHE_IDLE: begin
          if (accept) begin
            req_pc_d = pc_in;
            cnt_d    = '0;
`ifdef ICACHE_EN
            if (hit) begin
              ins_out_d = rd_data[pc_in[LINE_OFF_W-1:2]];
              state_d   = ICACHE_RESP;
            end else begin
              state_d   = ICACHE_REFILL;
            end
`else
            state_d = ICACHE_REFILL;
`endif
          end
        end
        ICACHE_REFILL: begin
          // The memory read cannot be aborted, so a flush only marks the result stale.
          if (flush) discard_d = 1'b1;
          if (mem_ack) begin
`ifdef ICACHE_EN
            wr_en = 1'b1;
            if (cnt_q == 2'd3) begin
              install   = 1'b1;
              ins_out_d = (req_word == cnt_q) ? mem_data : rd_data[req_word];
              state_d   = ICACHE_RESP;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
`else
            ins_out_d = mem_data;
            state_d   = ICACHE_RESP;
`endif
          end
        end
        ICACHE_RESP: begin
          state_d   = ICACHE_IDLE;
          discard_d = 1'b0;
        end
        default: state_d = ICACHE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ICACHE_IDLE;
      req_pc_q  <= '0;
      cnt_q     <= '0;
      ins_out_q <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      cnt_q     <= cnt_d;
      ins_out_q <= ins_out_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache; expectations adapt to whether ICACHE_EN is defined.
module tb_icache;

`ifdef ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif
  localparam int LAT_MISS   = CACHE_ON ? 5 : 2;
  localparam int LAT_HIT    = CACHE_ON ? 1 : 2;
  localparam int LINE_READS = CACHE_ON ? 4 : 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [31:0] pc_in = '0;
  logic        pc_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ins_out;
  logic        ins_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] addr_q[$];
  int          acks_total = 0;
  int          ack_limit = 1 << 30;
  int          req_cycles = 0;

  icache #(.INDEX_W(6), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .pc_in     (pc_in),
    .pc_valid  (pc_valid),
    .flush     (flush),
    .ins_out   (ins_out),
    .ins_valid (ins_valid),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a[31:4] == 28'd0) begin
      case (a[3:2])
        2'd0:    return 32'h11;
        2'd1:    return 32'h22;
        2'd2:    return 32'h33;
        default: return 32'h44;
      endcase
    end
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: one-cycle ack pulses, driven after the bench's own input updates.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mem_req) req_cycles++;
      if (mem_req && rdy && rst && acks_total < ack_limit) begin
        mem_ack  = 1'b1;
        mem_data = memw(mem_addr);
        addr_q.push_back(mem_addr);
        acks_total++;
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input int exp_lat,
                       input string tag);
    int          n;
    bit          seen;
    logic [31:0] got;
    @(negedge clk);
    pc_in = pc;
    pc_valid = 1'b1;
    n = 0;
    seen = 1'b0;
    got = '0;
    while (!seen && n < 40) begin
      @(negedge clk);
      #1;
      n++;
      if (ins_valid) begin
        seen = 1'b1;
        got = ins_out;
        pc_valid = 1'b0;
      end
    end
    pc_valid = 1'b0;
    chk({tag, "_valid"}, 32'(seen), 32'd1);
    chk({tag, "_data"}, got, exp);
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic check_reads(input string tag, input logic [31:0] pc);
    logic [31:0] exp;
    logic [31:0] act;
    chk({tag, "_nreads"}, addr_q.size(), LINE_READS);
    for (int i = 0; i < LINE_READS; i++) begin
      exp = CACHE_ON ? ({pc[31:4], 4'h0} + 32'(4 * i)) : pc;
      act = (i < addr_q.size()) ? addr_q[i] : 32'hDEAD_BEEF;
      chk($sformatf("%s_addr%0d", tag, i), act, exp);
    end
  endtask

  initial begin
    int  rc0;
    bit  seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ins_out", ins_out, 32'h0);

    addr_q.delete();
    fetch(32'h0000_0000, 32'h11, LAT_MISS, "cold_miss");
    check_reads("cold", 32'h0000_0000);
    rc0 = req_cycles;
    fetch(32'h0000_0008, 32'h33, LAT_HIT, "hit_08");
    chk("hit_08_reqcyc", req_cycles - rc0, CACHE_ON ? 0 : 1);

    fetch(32'h0000_0400, 32'hC0DE_0400, LAT_MISS, "conflict_400");
    addr_q.delete();
    fetch(32'h0000_0000, 32'h11, LAT_MISS, "conflict_000");
    check_reads("conflict", 32'h0000_0000);

    addr_q.delete();
    @(negedge clk);
    pc_in = 32'h0000_0010;
    pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_cycle_valid", 32'(ins_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ins_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_pulse", 32'(seen), 32'd0);
    check_reads("flush", 32'h0000_0010);
    fetch(32'h0000_0014, 32'hC0DE_0014, LAT_HIT, "after_flush");

    addr_q.delete();
    @(negedge clk);
    pc_in = 32'h0000_0020;
    pc_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall%0d_addr", i), mem_addr, CACHE_ON ? 32'h24 : 32'h20);
      chk($sformatf("stall%0d_req", i), 32'(mem_req), CACHE_ON ? 32'd1 : 32'd0);
      chk($sformatf("stall%0d_valid", i), 32'(ins_valid), 32'd0);
      @(negedge clk);
    end
    rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (ins_valid) begin
        seen = 1'b1;
        chk("stall_data", ins_out, 32'hC0DE_0020);
        pc_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    pc_valid = 1'b0;
    chk("stall_resumed", 32'(seen), 32'd1);
    check_reads("stall", 32'h0000_0020);

    addr_q.delete();
    ack_limit = acks_total + (CACHE_ON ? 2 : 0);
    @(negedge clk);
    pc_in = 32'h0000_0030;
    pc_valid = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    pc_valid = 1'b0;
    chk("pre_reset_req", 32'(mem_req), 32'd1);
    chk("pre_reset_addr", mem_addr, CACHE_ON ? 32'h38 : 32'h30);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_req", 32'(mem_req), 32'd0);
    chk("async_reset_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    ack_limit = 1 << 30;
    addr_q.delete();
    fetch(32'h0000_0030, 32'hC0DE_0030, LAT_MISS, "rerequest");
    check_reads("rerequest", 32'h0000_0030);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
